free_list_nway: RTL and testbench

// - N-way physical-register free list for the R10K rename stage; successor to the fixed 2-way list.
// - Circular buffer of free phys tags: dispatch allocates at head, ROB retirement returns old tags at tail.
// - Holds an internal per-branch checkpoint table of head pointers; on mispredict, head is rolled back so

---
 rtl/free_list_nway_pkg.sv | 30 +++
 rtl/free_list_nway_ckpt_table.sv | 30 +++
 rtl/free_list_nway.sv | 101 ++++++++++
 tb/tb_free_list_nway.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_nway_pkg.sv
// Shared rename-stage definitions for the N-way free list.
// Configuration constants, derived widths and pointer helpers.
package free_list_nway_pkg;

    localparam int WAYS     = 2;
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;
    localparam int NUM_BR   = 4;

    // DEPTH must be a power of two so pointers wrap naturally.
    localparam int DEPTH  = NUM_PHYS - NUM_ARCH;
    localparam int PHYS_W = $clog2(NUM_PHYS);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int BR_W   = $clog2(NUM_BR);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int NW_W   = $clog2(WAYS + 1);

    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [BR_W-1:0]   br_tag_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [NW_W-1:0]   nway_t;

    // Entry index addressed by a wrap-bit pointer.
    function automatic logic [IDX_W-1:0] ptr_idx(input fl_ptr_t p);
        return p[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/free_list_nway_ckpt_table.sv
// Per-branch checkpoint of the free-list head pointer.
// One write port, one asynchronous read port.
module free_list_nway_ckpt_table
    import free_list_nway_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    we,
    input  br_tag_t wtag,
    input  fl_ptr_t wdata,
    input  br_tag_t rtag,
    output fl_ptr_t rdata
);

    fl_ptr_t slots [NUM_BR];

    // Capture the head position for a newly dispatched branch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BR; i++) begin
                slots[i] <= '0;
            end
        end else if (we) begin
            slots[wtag] <= wdata;
        end
    end

    assign rdata = slots[rtag];

endmodule

// File: rtl/free_list_nway.sv
// N-way circular free list of physical tags for the rename stage.
// Head allocates, tail takes retired tags, head rolls back on mispredict.
module free_list_nway
    import free_list_nway_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  nway_t                haz_nDispatched,
    input  nway_t                rob_nRetired,
    input  phys_reg_t [WAYS-1:0] rob_retireTagOld,
    input  logic                 bs_ckptEn,
    input  br_tag_t              bs_ckptTag,
    input  nway_t                bs_ckptPos,
    input  logic                 br_fub_pred_wrong,
    input  br_tag_t              br_recovTag,
    output phys_reg_t [WAYS-1:0] fl_freeRegs,
    output cnt_t                 fl_availableRegs,
    output fl_ptr_t              fl_head
);

    phys_reg_t entries [DEPTH];
    fl_ptr_t   head;
    fl_ptr_t   tail;
    fl_ptr_t   head_next;
    fl_ptr_t   ckpt_head;
    fl_ptr_t   ckpt_wdata;
    fl_ptr_t   base_cnt;
    logic      ckpt_we;

    // A mispredicting cycle never records a checkpoint
    assign ckpt_we    = bs_ckptEn && !br_fub_pred_wrong;
    assign ckpt_wdata = head + fl_ptr_t'(bs_ckptPos);

    free_list_nway_ckpt_table u_ckpt (
        .clk   (clk),
        .reset (reset),
        .we    (ckpt_we),
        .wtag  (bs_ckptTag),
        .wdata (ckpt_wdata),
        .rtag  (br_recovTag),
        .rdata (ckpt_head)
    );

    // Next head: restore from checkpoint, else advance by dispatch count
    always_comb begin
        head_next = head + fl_ptr_t'(haz_nDispatched);
        if (br_fub_pred_wrong) begin
            head_next = ckpt_head;
        end
    end

    // Head and tail pointer registers; tail starts one full lap ahead
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= fl_ptr_t'(DEPTH);
        end else begin
            head <= head_next;
            tail <= tail + fl_ptr_t'(rob_nRetired);
        end
    end

    // Entry array: non-architectural tags at reset, retired tags at tail
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= phys_reg_t'(NUM_ARCH + i);
            end
        end else begin
            for (int k = 0; k < WAYS; k++) begin
                if (k < int'(rob_nRetired)) begin
                    entries[ptr_idx(tail + fl_ptr_t'(k))] <= rob_retireTagOld[k];
                end
            end
        end
    end

    // Combinational read of the next WAYS free tags starting at head
    always_comb begin
        for (int k = 0; k < WAYS; k++) begin
            fl_freeRegs[k] = entries[ptr_idx(head + fl_ptr_t'(k))];
        end
    end

    assign fl_availableRegs = cnt_t'(tail - head);
    assign fl_head          = head;

    // Occupancy the retire port adds to after this cycle's head update
    assign base_cnt = br_fub_pred_wrong ? (tail - ckpt_head)
                                        : (tail - head - fl_ptr_t'(haz_nDispatched));

    a_alloc: assert property (@(posedge clk) disable iff (reset)
        !br_fub_pred_wrong |-> (CNT_W'(haz_nDispatched) <= fl_availableRegs));

    a_full: assert property (@(posedge clk) disable iff (reset)
        (32'(base_cnt) + 32'(rob_nRetired)) <= 32'(DEPTH));

    a_ckpt_pos: assert property (@(posedge clk) disable iff (reset)
        bs_ckptEn |-> (bs_ckptPos <= haz_nDispatched));

endmodule

// File: tb/tb_free_list_nway.sv
// Bench for free_list_nway: directed spec scenarios plus random traffic.
// Reference model keeps free tags as an ordered queue of tag values.
module tb_free_list_nway;
    import free_list_nway_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset;
    nway_t                nd_in;
    nway_t                nr_in;
    phys_reg_t [WAYS-1:0] rtags;
    logic                 cen;
    br_tag_t              ctag;
    nway_t                cpos_in;
    logic                 pw;
    br_tag_t              rtag_in;
    phys_reg_t [WAYS-1:0] free_regs;
    cnt_t                 avail;
    fl_ptr_t              head;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: free tags in allocation order, committed tags,
    // tags allocated after the live checkpoint, and total head movement.
    int freeq[$];
    int held[$];
    int spec[$];
    int mhead;
    bit ck_live;
    int ck_slot;

    free_list_nway dut (
        .clk               (clk),
        .reset             (reset),
        .haz_nDispatched   (nd_in),
        .rob_nRetired      (nr_in),
        .rob_retireTagOld  (rtags),
        .bs_ckptEn         (cen),
        .bs_ckptTag        (ctag),
        .bs_ckptPos        (cpos_in),
        .br_fub_pred_wrong (pw),
        .br_recovTag       (rtag_in),
        .fl_freeRegs       (free_regs),
        .fl_availableRegs  (avail),
        .fl_head           (head)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        nd_in   = '0;
        nr_in   = '0;
        rtags   = '0;
        cen     = 1'b0;
        ctag    = '0;
        cpos_in = '0;
        pw      = 1'b0;
        rtag_in = '0;
    endtask

    task automatic model_reset();
        freeq.delete();
        held.delete();
        spec.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(NUM_ARCH + i);
        for (int i = 0; i < NUM_ARCH; i++) held.push_back(i);
        mhead   = 0;
        ck_live = 1'b0;
        ck_slot = 0;
    endtask

    task automatic model_check(input string tag);
        check($sformatf("%s c%0d count", tag, cyc), 32'(avail), 32'(freeq.size()));
        check($sformatf("%s c%0d head", tag, cyc), 32'(head),
              32'(mhead % (2 * DEPTH)));
        for (int k = 0; k < WAYS && k < freeq.size(); k++) begin
            check($sformatf("%s c%0d free%0d", tag, cyc, k),
                  32'(free_regs[k]), 32'(freeq[k]));
        end
    endtask

    function automatic int take_random();
        int i;
        int t;
        i = int'($urandom_range(held.size() - 1, 0));
        t = held[i];
        held.delete(i);
        return t;
    endfunction

    function automatic int take(input int t);
        for (int i = 0; i < held.size(); i++) begin
            if (held[i] == t) begin
                held.delete(i);
                return t;
            end
        end
        return t;
    endfunction

    task automatic step(input string tag, input int nd, input int nr,
                        input int t0, input int t1, input bit ce,
                        input int cs, input int cp, input bit pwv);
        int rt[2];
        int t;
        rt[0]    = t0;
        rt[1]    = t1;
        nd_in    = nway_t'(nd);
        nr_in    = nway_t'(nr);
        rtags[0] = phys_reg_t'(t0);
        rtags[1] = phys_reg_t'(t1);
        cen      = ce;
        ctag     = br_tag_t'(cs);
        cpos_in  = nway_t'(cp);
        pw       = pwv;
        rtag_in  = br_tag_t'(ck_slot);
        @(posedge clk);
        cyc++;
        if (pwv) begin
            for (int i = spec.size() - 1; i >= 0; i--) freeq.push_front(spec[i]);
            mhead   = mhead - spec.size();
            spec.delete();
            ck_live = 1'b0;
        end else begin
            for (int i = 0; i < nd; i++) begin
                t = freeq.pop_front();
                if (ck_live || (ce && i >= cp)) spec.push_back(t);
                else held.push_back(t);
            end
            mhead = mhead + nd;
            if (ce) begin
                ck_live = 1'b1;
                ck_slot = cs;
            end
        end
        for (int k = 0; k < nr; k++) freeq.push_back(rt[k]);
        #1;
        idle();
        model_check(tag);
    endtask

    initial begin
        int nd;
        int nr;
        int cp;
        int t0;
        int t1;
        bit ce;
        bit pwv;
        reset = 1'b1;
        idle();
        model_reset();
        #1;
        check("reset count", 32'(avail), 32'd32);
        check("reset free0", 32'(free_regs[0]), 32'd32);
        check("reset free1", 32'(free_regs[1]), 32'd33);
        check("reset head", 32'(head), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Checkpoint with pos 1 at head 4, then roll back to head 5
        step("pre", 2, 0, 0, 0, 0, 0, 0, 0);
        step("pre", 2, 0, 0, 0, 0, 0, 0, 0);
        step("ck1", 2, 0, 0, 0, 1, 1, 1, 0);
        step("spec", 2, 0, 0, 0, 0, 0, 0, 0);
        step("spec", 2, 0, 0, 0, 0, 0, 0, 0);
        check("pre-recov count", 32'(avail), 32'd22);
        step("recov", 0, 0, 0, 0, 0, 0, 0, 1);
        check("recov head", 32'(head), 32'd5);
        check("recov count", 32'(avail), 32'd27);
        check("recov free0", 32'(free_regs[0]), 32'd37);

        // Mispredict with concurrent retire and ignored dispatch
        step("ck2", 2, 0, 0, 0, 1, 2, 0, 0);
        step("spec2", 2, 0, 0, 0, 0, 0, 0, 0);
        t0 = take_random();
        t1 = take_random();
        step("recov2", 2, 2, t0, t1, 0, 0, 0, 1);
        check("recov2 head", 32'(head), 32'd5);
        check("recov2 count", 32'(avail), 32'd29);

        // Asynchronous reset between clock edges during a burst
        nd_in = nway_t'(2);
        #3;
        reset = 1'b1;
        #1;
        check("async rst count", 32'(avail), 32'd32);
        check("async rst head", 32'(head), 32'd0);
        check("async rst free0", 32'(free_regs[0]), 32'd32);
        idle();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        model_check("post rst");

        // Drain with 2 allocations per cycle
        for (int c = 0; c < 16; c++) begin
            check($sformatf("drain%0d free0", c), 32'(free_regs[0]), 32'(32 + 2 * c));
            check($sformatf("drain%0d free1", c), 32'(free_regs[1]), 32'(33 + 2 * c));
            check($sformatf("drain%0d count", c), 32'(avail), 32'(32 - 2 * c));
            step("drain", 2, 0, 0, 0, 0, 0, 0, 0);
        end
        check("empty count", 32'(avail), 32'd0);
        step("empty hold", 0, 0, 0, 0, 0, 0, 0, 0);
        check("empty held", 32'(avail), 32'd0);

        // Refill from empty, then hand the tags back out in order
        step("ret59", 0, 2, take(5), take(9), 0, 0, 0, 0);
        step("ret12", 0, 1, take(12), 0, 0, 0, 0, 0);
        check("refill count", 32'(avail), 32'd3);
        check("refill free0", 32'(free_regs[0]), 32'd5);
        check("refill free1", 32'(free_regs[1]), 32'd9);
        step("realloc", 2, 0, 0, 0, 0, 0, 0, 0);
        check("realloc free0", 32'(free_regs[0]), 32'd12);
        check("realloc count", 32'(avail), 32'd1);
        step("realloc", 1, 0, 0, 0, 0, 0, 0, 0);

        // Alternate retire 2 / dispatch 2 so both pointers wrap
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) begin
                t0 = take_random();
                t1 = take_random();
                step("wrap ret", 0, 2, t0, t1, 0, 0, 0, 0);
            end else begin
                step("wrap disp", 2, 0, 0, 0, 0, 0, 0, 0);
                check($sformatf("wrap%0d count", c), 32'(avail), 32'd0);
            end
        end

        // Random traffic with one live checkpoint at a time
        for (int c = 0; c < 500; c++) begin
            pwv = ck_live && ($urandom_range(7, 0) == 0);
            if (ck_live && !pwv && $urandom_range(9, 0) == 0) begin
                for (int i = 0; i < spec.size(); i++) held.push_back(spec[i]);
                spec.delete();
                ck_live = 1'b0;
            end
            if (pwv) nd = int'($urandom_range(2, 0));
            else nd = int'($urandom_range((freeq.size() < 2) ? freeq.size() : 2, 0));
            nr = held.size() - NUM_ARCH;
            nr = int'($urandom_range((nr < 2) ? nr : 2, 0));
            t0 = (nr > 0) ? take_random() : int'($urandom_range(63, 0));
            t1 = (nr > 1) ? take_random() : int'($urandom_range(63, 0));
            ce = !ck_live && !pwv && ($urandom_range(5, 0) == 0);
            cp = int'($urandom_range(nd, 0));
            step("rand", nd, nr, t0, t1, ce, int'($urandom_range(NUM_BR - 1, 0)),
                 ce ? cp : 0, pwv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
